mode4_adder_ctrl: RTL and testbench

- Sequencing controller for the 4-input pipelined FP adder tree: two stage-2 adders, one stage-1 adder, and a stage-0 accumulator that adds into its own output register.
- Accepts a stream of 4-element groups from upstream over a valid/ready handshake.
- Drives the tree's per-stage run enables and its accumulator clear.
- Signals completion when the accumulated sum of NUM groups is stable on the tree output.

---
 rtl/mode4_adder_ctrl_pkg.sv | 15 +
 rtl/mode4_run_shift.sv | 40 ++++
 rtl/mode4_adder_ctrl.sv | 103 ++++++++++
 tb/tb_mode4_adder_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode4_adder_ctrl_pkg.sv
// Shared definitions for the 4-input FP adder tree sequencing controller.
package mode4_adder_ctrl_pkg;

  localparam int CNT_WIDTH_DEF  = 16;
  localparam int TREE_DEPTH_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mode4_run_shift.sv
// Valid shift register that follows each stage-2 capture down the tree so
// stage-1 and the accumulator only fire for real data (bubbles propagate).
module mode4_run_shift
  import mode4_adder_ctrl_pkg::*;
#(
  parameter int TREE_DEPTH = TREE_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic stage2_run,
  output logic stage1_run,
  output logic stage0_run,
  output logic drain_empty
);

  localparam int SR_W = TREE_DEPTH - 1;
  // Every bit except the oldest one; after the next shift those are all that remain.
  localparam logic [SR_W-1:0] KEEP_MASK = ~(SR_W'(1) << (SR_W - 1));

  // vld_p[0] is the stage-1 valid, vld_p[SR_W-1] the accumulator valid
  logic [SR_W-1:0] vld_p;

  // Shift the handshake valid one stage per cycle; reset discards in-flight groups
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= stage2_run;
      for (int i = 1; i < SR_W; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign stage1_run  = vld_p[0];
  assign stage0_run  = vld_p[SR_W-1];
  // True when the pipeline will hold no valid bits once this cycle's shift lands
  assign drain_empty = !stage2_run && ((vld_p & KEEP_MASK) == '0);

endmodule

// File: rtl/mode4_adder_ctrl.sv
// Sequencing controller for the 4-input pipelined FP adder tree: accepts
// NUM groups over valid/ready, drives the per-stage run enables and the
// accumulator clear, and pulses sum_valid once the final sum is on outp.
module mode4_adder_ctrl
  import mode4_adder_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int TREE_DEPTH = TREE_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_groups,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 stage2_run,
  output logic                 stage1_run,
  output logic                 stage0_run,
  output logic                 tree_clear,
  output logic                 busy,
  output logic                 sum_valid,
  output logic [CNT_WIDTH-1:0] groups_done
);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] num_lat;
  logic                 clr_q;
  logic                 drain_empty;
  logic                 start_acc;

  assign start_acc = (state_q == ST_IDLE) && start;

  // Next-state and handshake decode; in_ready depends on state only, never on in_valid
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    stage2_run = 1'b0;
    busy       = 1'b1;
    sum_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = (num_lat == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        in_ready   = (groups_done < num_lat);
        stage2_run = in_valid && in_ready;
        if (stage2_run && ((groups_done + CNT_WIDTH'(1)) == num_lat)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        sum_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Group counter clears on entry to CLEAR and holds its final value afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      groups_done <= '0;
      num_lat     <= '0;
    end else if (start_acc) begin
      groups_done <= '0;
      num_lat     <= num_groups;
    end else if (stage2_run) begin
      groups_done <= groups_done + CNT_WIDTH'(1);
    end
  end

  // Post-reset clear: held during reset and for the first cycle after release
  always_ff @(posedge clk) begin
    if (!reset) clr_q <= 1'b1;
    else        clr_q <= 1'b0;
  end

  assign tree_clear = clr_q || (state_q == ST_CLEAR);

  mode4_run_shift #(
    .TREE_DEPTH (TREE_DEPTH)
  ) u_run_shift (
    .clk         (clk),
    .reset       (reset),
    .stage2_run  (stage2_run),
    .stage1_run  (stage1_run),
    .stage0_run  (stage0_run),
    .drain_empty (drain_empty)
  );

endmodule

// File: tb/tb_mode4_adder_ctrl.sv
// Bench for mode4_adder_ctrl: a behavioural adder tree (integer values) is
// driven by the controller's enables; expected sums, counts and sum_valid
// cycles are pushed to a scoreboard and checked by a separate monitor.
module tb_mode4_adder_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_groups = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, stage2_run, stage1_run, stage0_run;
  logic          tree_clear, busy, sum_valid;
  logic [CW-1:0] groups_done;

  mode4_adder_ctrl #(.CNT_WIDTH(CW), .TREE_DEPTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_groups  (num_groups),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stage2_run  (stage2_run),
    .stage1_run  (stage1_run),
    .stage0_run  (stage0_run),
    .tree_clear  (tree_clear),
    .busy        (busy),
    .sum_valid   (sum_valid),
    .groups_done (groups_done)
  );

  always #5 clk = ~clk;

  // Behavioural adder tree (the plant)
  int inp0 = 0, inp1 = 0, inp2 = 0, inp3 = 0;
  int s2a = 0, s2b = 0, s1 = 0, outp = 0;

  always @(posedge clk) begin
    if (tree_clear) begin
      s2a <= 0; s2b <= 0; s1 <= 0; outp <= 0;
    end else begin
      if (stage2_run) begin
        s2a <= inp0 + inp1;
        s2b <= inp2 + inp3;
      end
      if (stage1_run) s1 <= s2a + s2b;
      if (stage0_run) outp <= outp + s1;
    end
  end

  // Checking bookkeeping
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit rst_edge = 1'b1;
  bit armed = 1'b0;
  int run0_cnt = 0;
  int run_any_cnt = 0;
  int last_acc = 0;

  typedef struct {
    int sum;
    int n;
    int cyc;
  } exp_t;
  exp_t sbq[$];

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = !reset;
  end

  // Monitor: run-enable delay relation and scoreboard pops on sum_valid
  bit p_s2 = 1'b0, p_e1 = 1'b0;
  always @(negedge clk) begin
    bit e1, e0;
    exp_t e;
    if (armed) begin
      e1 = rst_edge ? 1'b0 : p_s2;
      e0 = rst_edge ? 1'b0 : p_e1;
      if (e1 || e0 || stage1_run || stage0_run) begin
        chk("stage1_run_delay", int'(stage1_run), int'(e1));
        chk("stage0_run_delay", int'(stage0_run), int'(e0));
      end
      p_s2 = stage2_run;
      p_e1 = e1;
      if (stage0_run) run0_cnt++;
      if (stage0_run || stage1_run || stage2_run) run_any_cnt++;
      if (sum_valid) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sum_valid_cycle", cyc, e.cyc);
          chk("outp_sum", outp, e.sum);
          chk("groups_done", int'(groups_done), e.n);
        end else begin
          chk("unexpected_sum_valid", 1, 0);
        end
      end
    end
  end

  // Drive start in this cycle, then step through CLEAR (tree_clear must be high there)
  task automatic kick(input int n);
    start = 1'b1;
    num_groups = CW'(n);
    if (n == 0) sbq.push_back('{0, 0, cyc + 2});
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("tree_clear_in_clear", int'(tree_clear), 1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input bit v, input int a, input int b, input int c, input int d);
    in_valid = v;
    inp0 = a; inp1 = b; inp2 = c; inp3 = d;
    @(negedge clk);
    chk("stage2_run", int'(stage2_run), int'(v));
    if (v) last_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic finish_red(input int sum, input int n);
    sbq.push_back('{sum, n, last_acc + 3});
    wait_idle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int r0;
    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_stage2", int'(stage2_run), 0);
    chk("rst_stage1", int'(stage1_run), 0);
    chk("rst_stage0", int'(stage0_run), 0);
    chk("rst_groups_done", int'(groups_done), 0);
    chk("rst_tree_clear", int'(tree_clear), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("tree_clear_release0", int'(tree_clear), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tree_clear_release1", int'(tree_clear), 0);
    @(posedge clk); #1;

    // Three groups, continuous valid: 10 + 26 + 4 = 40
    r0 = run0_cnt;
    kick(3);
    feed(1'b1, 1, 2, 3, 4);
    feed(1'b1, 5, 6, 7, 8);
    feed(1'b1, 1, 1, 1, 1);
    finish_red(40, 3);
    chk("s1_stage0_count", run0_cnt - r0, 3);
    chk("groups_done_held_idle", int'(groups_done), 3);
    chk("tree_clear_idle", int'(tree_clear), 0);

    // Two groups with a bubble carrying junk data: 10 + 8 = 18
    r0 = run0_cnt;
    kick(2);
    feed(1'b1, 1, 2, 3, 4);
    feed(1'b0, 100, 100, 100, 100);
    feed(1'b1, 2, 2, 2, 2);
    finish_red(18, 2);
    chk("s2_stage0_count", run0_cnt - r0, 2);

    // Zero groups: sum_valid two cycles after start, outp cleared, no runs
    r0 = run_any_cnt;
    kick(0);
    wait_idle();
    chk("s3_no_runs", run_any_cnt - r0, 0);

    // Back-to-back single-group reductions: 10 then 4 (not 14)
    kick(1);
    feed(1'b1, 1, 2, 3, 4);
    finish_red(10, 1);
    kick(1);
    feed(1'b1, 1, 1, 1, 1);
    finish_red(4, 1);

    // Reset during RUN after 2 of 5 groups
    kick(5);
    feed(1'b1, 1, 1, 1, 1);
    feed(1'b1, 2, 2, 2, 2);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_stage2", int'(stage2_run), 0);
    chk("midrst_stage1", int'(stage1_run), 0);
    chk("midrst_stage0", int'(stage0_run), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tree_clear_release", int'(tree_clear), 1);
    chk("midrst_busy_release", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_outp_zeroed", outp, 0);
    @(posedge clk); #1;
    kick(1);
    feed(1'b1, 1, 1, 1, 1);
    finish_red(4, 1);

    // start during DRAIN with a different count is ignored: 10 + 26 = 36
    kick(2);
    feed(1'b1, 1, 2, 3, 4);
    feed(1'b1, 5, 6, 7, 8);
    sbq.push_back('{36, 2, last_acc + 3});
    start = 1'b1;
    num_groups = CW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_start_ignored_busy", int'(busy), 0);
    chk("drain_start_groups_done", int'(groups_done), 2);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
